// File: rtl/psram_arb_pkg.sv
// Shared encodings for the two-master PSRAM Wishbone arbiter.
package psram_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // One-hot grant encodings, bit order {M1,M0}.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Width of the consecutive-M0-grant counter; MAX_BURST is at most 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/psram_arb_pick.sv
// Combinational grant pick: fixed priority to M0, except that M1 gets the
// turn once M0 has won MAX_BURST consecutive arbitrations while M1 waited.
module psram_arb_pick
  import psram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             req0,
  input  logic             req1,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [1:0]       gnt_next
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // Priority pick with starvation override.
  always_comb begin
    gnt_next = GNT_NONE;
    if (req0 && req1) begin
      gnt_next = (burst_cnt == MAX_CNT) ? GNT_M1 : GNT_M0;
    end else if (req0) begin
      gnt_next = GNT_M0;
    end else if (req1) begin
      gnt_next = GNT_M1;
    end
  end

endmodule

// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of a single-port PSRAM
// controller. One master owns the controller per transaction; a mandatory
// idle cycle follows every ack so a held strobe is never seen as a new access.
module psram_wb_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // Master 0
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  output logic            m0_ack_o,
  // Master 1
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  output logic            m1_ack_o,
  // PSRAM controller
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  input  logic            s_ack_i,
  // Status
  output logic [1:0]      gnt_o,
  output logic            busy_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // Saturating increment of the consecutive-M0 counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             drop_q, drop_d;

  logic             req0, req1;
  logic [1:0]       gnt_pick;
  logic             own_cyc;
  logic             busy;
  logic             fwd_ack;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  psram_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .req0      (req0),
    .req1      (req1),
    .burst_cnt (burst_cnt_q),
    .gnt_next  (gnt_pick)
  );

  // Control state register; everything here is control so all of it resets.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_NONE;
      burst_cnt_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
      drop_q      <= drop_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for the controller ack in BUSY,
  // then spend exactly one GAP cycle before arbitrating again.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    burst_cnt_d = burst_cnt_q;
    drop_d      = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_pick != GNT_NONE) begin
          state_d = ST_BUSY;
          gnt_d   = gnt_pick;
          drop_d  = 1'b0;
          // Count only M0 wins that made M1 wait.
          if (gnt_pick == GNT_M0 && req1) begin
            burst_cnt_d = sat_inc(burst_cnt_q, MAX_CNT);
          end else begin
            burst_cnt_d = '0;
          end
        end
      end
      ST_BUSY: begin
        // The controller cannot abort, so a master that gives up its cycle
        // only loses the ack; the access itself runs to completion.
        if (!own_cyc) begin
          drop_d = 1'b1;
        end
        if (s_ack_i) begin
          state_d = ST_GAP;
          gnt_d   = GNT_NONE;
          drop_d  = 1'b0;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Slave-side mux and ack routing; outputs are zero whenever not BUSY.
  always_comb begin
    busy    = (state_q == ST_BUSY);
    own_cyc = gnt_q[1] ? m1_cyc_i : m0_cyc_i;
    fwd_ack = busy & s_ack_i & ~drop_q & own_cyc;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    if (busy && gnt_q[1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
    end else if (busy && gnt_q[0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
    end
    s_cyc_o  = busy;
    s_stb_o  = busy;
    m0_ack_o = fwd_ack & gnt_q[0];
    m1_ack_o = fwd_ack & gnt_q[1];
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    gnt_o    = gnt_q;
    busy_o   = busy;
  end

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Directed bench for psram_wb_arbiter. Inputs change and outputs are sampled
// in the low half of the clock, away from the rising edge.
module tb_psram_wb_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   m0_adr, m1_adr, s_adr;
  logic [DW-1:0]   m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic            m0_cyc, m0_stb, m0_we, m0_ack;
  logic            m1_cyc, m1_stb, m1_we, m1_ack;
  logic            s_cyc, s_stb, s_we, s_ack;
  logic [1:0]      gnt;
  logic            busy;

  int n_chk  = 0;
  int n_pass = 0;

  psram_wb_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_wdat),
    .m0_dat_o (m0_rdat),
    .m0_sel_i (m0_sel),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_ack_o (m0_ack),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_wdat),
    .m1_dat_o (m1_rdat),
    .m1_sel_i (m1_sel),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_ack_o (m1_ack),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_dat_i  (s_rdat),
    .s_sel_o  (s_sel),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_ack_i  (s_ack),
    .gnt_o    (gnt),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to the next low half-cycle and let combinational outputs settle.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for the arbiter to enter BUSY.
  task automatic wait_busy(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nxt();
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " busy"}, 64'(seen), 64'd1);
  endtask

  // One arbitration round: expect the given grant, ack it one cycle later.
  task automatic run_grant(input string tag, input logic [1:0] exp_gnt);
    wait_busy(tag);
    chk({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
    @(negedge clk);
    s_ack  = 1'b1;
    s_rdat = 32'h1234_0000;
    #1;
    chk({tag, " ack"}, 64'({m1_ack, m0_ack}), 64'(exp_gnt));
    @(negedge clk);
    s_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_adr = '0; m0_wdat = '0; m0_sel = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_adr = '0; m1_wdat = '0; m1_sel = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_rdat = '0; s_ack = 0;

    // Reset state
    nxt(); nxt();
    chk("rst gnt", 64'(gnt), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst s_cyc_stb_we", 64'({s_cyc, s_stb, s_we}), 64'd0);
    chk("rst s_adr", 64'(s_adr), 64'd0);
    chk("rst acks", 64'({m1_ack, m0_ack}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: M0 read of 0x10, controller acks after 20 cycles
    m0_adr = 32'h0000_0010; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1; m0_we = 0;
    #1;
    chk("t1 idle no stb", 64'(s_stb), 64'd0);
    wait_busy("t1");
    chk("t1 gnt", 64'(gnt), 64'b01);
    chk("t1 s_adr", 64'(s_adr), 64'h10);
    for (int i = 0; i < 19; i++) nxt();
    chk("t1 stb held", 64'({s_cyc, s_stb}), 64'b11);
    @(negedge clk);
    s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    #1;
    chk("t1 m0_ack", 64'(m0_ack), 64'd1);
    chk("t1 m0_dat", 64'(m0_rdat), 64'hDEAD_BEEF);
    chk("t1 m1_ack", 64'(m1_ack), 64'd0);
    @(negedge clk);
    s_ack = 1'b0; m0_cyc = 0; m0_stb = 0;
    #1;
    chk("t1 gap stb", 64'(s_stb), 64'd0);
    chk("t1 gap gnt", 64'(gnt), 64'd0);
    chk("t1 gap m0_ack", 64'(m0_ack), 64'd0);
    nxt();
    chk("t1 idle after gap", 64'(busy), 64'd0);

    // 2: both masters request continuously -> M0 x4, M1, M0 x4, M1
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    m1_adr = 32'h0000_0040; m1_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      run_grant($sformatf("t2[%0d]", i), (i % 5 == 4) ? 2'b10 : 2'b01);
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt(); nxt();
    chk("t2 idle", 64'(busy), 64'd0);

    // 3: M1 write, M0 arrives mid-transaction and waits for gap
    m1_adr = 32'h20; m1_wdat = 32'hA5; m1_sel = 4'b0100; m1_we = 1; m1_cyc = 1; m1_stb = 1;
    wait_busy("t3");
    chk("t3 gnt", 64'(gnt), 64'b10);
    chk("t3 s_we", 64'(s_we), 64'd1);
    chk("t3 s_sel", 64'(s_sel), 64'b0100);
    chk("t3 s_adr", 64'(s_adr), 64'h20);
    chk("t3 s_dat", 64'(s_wdat), 64'hA5);
    @(negedge clk);
    m0_adr = 32'h30; m0_sel = 4'hF; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    #1;
    nxt(); nxt();
    chk("t3 still m1", 64'(gnt), 64'b10);
    chk("t3 held sel_we", 64'({s_sel, s_we}), 64'b0100_1);
    chk("t3 m0 waits", 64'(m0_ack), 64'd0);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("t3 acks", 64'({m1_ack, m0_ack}), 64'b10);
    @(negedge clk);
    s_ack = 1'b0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1;
    chk("t3 gap", 64'({busy, gnt}), 64'd0);
    nxt();
    chk("t3 idle", 64'(busy), 64'd0);
    nxt();
    chk("t3 m0 after gap", 64'({busy, gnt}), 64'b1_01);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    @(negedge clk);
    s_ack = 1'b0; m0_cyc = 0; m0_stb = 0;
    nxt(); nxt();

    // 4: back-to-back M0 with strobe held through ack
    m0_adr = 32'h50; m0_cyc = 1; m0_stb = 1;
    wait_busy("t4");
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("t4 ack1", 64'(m0_ack), 64'd1);
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk("t4 gap stb", 64'(s_stb), 64'd0);
    nxt();
    chk("t4 idle stb", 64'(s_stb), 64'd0);
    nxt();
    chk("t4 second stb", 64'({s_stb, gnt}), 64'b1_01);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("t4 ack2", 64'(m0_ack), 64'd1);
    @(negedge clk);
    s_ack = 1'b0; m0_cyc = 0; m0_stb = 0;
    nxt(); nxt();

    // 5: M0 abandons its cycle before ack
    m0_adr = 32'h60; m0_cyc = 1; m0_stb = 1;
    wait_busy("t5");
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    #1;
    chk("t5 stb held", 64'({s_cyc, s_stb}), 64'b11);
    nxt(); nxt();
    chk("t5 stb still held", 64'({s_cyc, s_stb}), 64'b11);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("t5 ack swallowed", 64'({m1_ack, m0_ack}), 64'd0);
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk("t5 gap stb", 64'(s_stb), 64'd0);
    nxt(); nxt();
    chk("t5 idle", 64'({busy, gnt}), 64'd0);

    // 6: reset mid-BUSY clears state and the starvation counter
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h70;
    run_grant("t6 pre0", 2'b01);
    wait_busy("t6 pre1");
    chk("t6 pre1 gnt", 64'(gnt), 64'b01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_ack = 1'b1;
    #1;
    chk("t6 rst s_out", 64'({s_cyc, s_stb, s_we}), 64'd0);
    chk("t6 rst s_adr", 64'(s_adr), 64'd0);
    chk("t6 rst gnt_busy", 64'({busy, gnt}), 64'd0);
    chk("t6 stray ack", 64'({m1_ack, m0_ack}), 64'd0);
    #1;
    s_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_grant($sformatf("t6[%0d]", i), (i == 4) ? 2'b10 : 2'b01);
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
